// File: rtl/collision_scheduler.sv
// Per-tick collision scan: every shot against every asteroid, then the ship against every asteroid,
// one pair per cycle through a shared compare, issuing delete requests and tracking score/lives.
module collision_scheduler #(
  parameter int ENTITY_SIZE   = 34,
  parameter int MAX_SHOTS     = 3,
  parameter int MAX_ASTEROIDS = 4,
  parameter int HIT_R         = 8,
  parameter int SHIP_R        = 6,
  parameter int SCORE_W       = 16,
  parameter int LIVES_INIT    = 3,
  localparam int SW = (MAX_SHOTS > 1) ? $clog2(MAX_SHOTS) : 1,
  localparam int AW = (MAX_ASTEROIDS > 1) ? $clog2(MAX_ASTEROIDS) : 1
) (
  input  logic                                  move_clk,
  input  logic                                  reset_n,
  input  logic                                  start,
  input  logic [ENTITY_SIZE-1:0]                ship,
  input  logic [MAX_ASTEROIDS*ENTITY_SIZE-1:0]  asteroids,
  input  logic [MAX_SHOTS*ENTITY_SIZE-1:0]      shots,
  input  logic                                  del_ack,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  del_valid,
  output logic [SW-1:0]                         del_shot_addr,
  output logic [AW-1:0]                         del_ast_addr,
  output logic                                  ship_hit,
  output logic [SCORE_W-1:0]                    score,
  output logic [3:0]                            lives,
  output logic                                  game_over
);

  // state     | meaning
  // S_IDLE    | waiting for start (ignored once game_over)
  // S_SNAP    | latch entity words into local copies
  // S_SHOT    | compare shot[i] vs asteroid[j]
  // S_HIT_REQ | hold delete request until del_ack
  // S_SHIP    | compare ship vs asteroid[j]
  // S_DONE    | one-cycle done pulse
  typedef enum logic [2:0] {S_IDLE, S_SNAP, S_SHOT, S_HIT_REQ, S_SHIP, S_DONE} state_t;

  localparam logic signed [10:0] HIT_LIM  = 11'(HIT_R);
  localparam logic signed [10:0] SHIP_LIM = 11'(SHIP_R);
  localparam logic [SW-1:0]      LAST_SHOT = SW'(MAX_SHOTS - 1);
  localparam logic [AW-1:0]      LAST_AST  = AW'(MAX_ASTEROIDS - 1);

  state_t        state, state_nxt;
  logic [SW-1:0] i_q;
  logic [AW-1:0] j_q;

  logic       shot_act [MAX_SHOTS];
  logic [9:0] shot_x   [MAX_SHOTS];
  logic [9:0] shot_y   [MAX_SHOTS];
  logic       ast_act  [MAX_ASTEROIDS];
  logic [9:0] ast_x    [MAX_ASTEROIDS];
  logic [9:0] ast_y    [MAX_ASTEROIDS];
  logic       ship_act;
  logic [9:0] ship_x, ship_y;

  logic shot_hit_c, ship_hit_c;

  // Direction and spare bits are carried in the entity words but play no part in overlap.
  logic unused_bits;
  assign unused_bits = ^{ship, asteroids, shots};

  function automatic logic near(input logic [9:0] a, input logic [9:0] b,
                                input logic signed [10:0] lim);
    logic signed [10:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d[10]) d = -d;
    return d < lim;
  endfunction

  always_comb begin
    shot_hit_c = shot_act[i_q] & ast_act[j_q] &
                 near(shot_x[i_q], ast_x[j_q], HIT_LIM) &
                 near(shot_y[i_q], ast_y[j_q], HIT_LIM);
    ship_hit_c = ship_act & ast_act[j_q] &
                 near(ship_x, ast_x[j_q], SHIP_LIM) &
                 near(ship_y, ast_y[j_q], SHIP_LIM);
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    del_valid = 1'b0;
    case (state)
      S_IDLE: if (start && !game_over) state_nxt = S_SNAP;
      S_SNAP: begin
        busy      = 1'b1;
        state_nxt = S_SHOT;
      end
      S_SHOT: begin
        busy = 1'b1;
        if (shot_hit_c)                                state_nxt = S_HIT_REQ;
        else if (i_q == LAST_SHOT && j_q == LAST_AST)  state_nxt = S_SHIP;
      end
      S_HIT_REQ: begin
        busy      = 1'b1;
        del_valid = 1'b1;
        if (del_ack) state_nxt = (i_q == LAST_SHOT) ? S_SHIP : S_SHOT;
      end
      S_SHIP: begin
        busy = 1'b1;
        if (ship_hit_c || j_q == LAST_AST) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge move_clk) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      i_q           <= '0;
      j_q           <= '0;
      del_shot_addr <= '0;
      del_ast_addr  <= '0;
      ship_hit      <= 1'b0;
      score         <= '0;
      lives         <= 4'(LIVES_INIT);
      game_over     <= 1'b0;
      ship_act      <= 1'b0;
      ship_x        <= '0;
      ship_y        <= '0;
      for (int k = 0; k < MAX_SHOTS; k++) begin
        shot_act[k] <= 1'b0;
        shot_x[k]   <= '0;
        shot_y[k]   <= '0;
      end
      for (int k = 0; k < MAX_ASTEROIDS; k++) begin
        ast_act[k] <= 1'b0;
        ast_x[k]   <= '0;
        ast_y[k]   <= '0;
      end
    end else begin
      state    <= state_nxt;
      ship_hit <= 1'b0;
      case (state)
        S_SNAP: begin
          i_q      <= '0;
          j_q      <= '0;
          ship_act <= ship[33];
          ship_x   <= ship[15:6];
          ship_y   <= ship[25:16];
          for (int k = 0; k < MAX_SHOTS; k++) begin
            shot_act[k] <= shots[k*ENTITY_SIZE + 33];
            shot_x[k]   <= shots[k*ENTITY_SIZE + 6 +: 10];
            shot_y[k]   <= shots[k*ENTITY_SIZE + 16 +: 10];
          end
          for (int k = 0; k < MAX_ASTEROIDS; k++) begin
            ast_act[k] <= asteroids[k*ENTITY_SIZE + 33];
            ast_x[k]   <= asteroids[k*ENTITY_SIZE + 6 +: 10];
            ast_y[k]   <= asteroids[k*ENTITY_SIZE + 16 +: 10];
          end
        end
        S_SHOT: begin
          if (shot_hit_c) begin
            // Clearing the local copies keeps one shot or asteroid from being killed twice.
            del_shot_addr <= i_q;
            del_ast_addr  <= j_q;
            shot_act[i_q] <= 1'b0;
            ast_act[j_q]  <= 1'b0;
          end else if (j_q == LAST_AST) begin
            j_q <= '0;
            i_q <= (i_q == LAST_SHOT) ? '0 : i_q + 1'b1;
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        S_HIT_REQ: begin
          if (del_ack) begin
            if (score != '1) score <= score + 1'b1;
            j_q <= '0;
            i_q <= (i_q == LAST_SHOT) ? '0 : i_q + 1'b1;
          end
        end
        S_SHIP: begin
          if (ship_hit_c) begin
            ship_hit <= 1'b1;
            if (lives != 4'd0)  lives     <= lives - 4'd1;
            if (lives <= 4'd1)  game_over <= 1'b1;
          end else if (j_q != LAST_AST) begin
            j_q <= j_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
